uart_tx_fifo: RTL and testbench

Serial UART transmitter with an input byte FIFO; sits directly downstream of the ASCII packet formatter and drives the board's USB-UART TX pin. It accepts bytes over a valid/ready byte stream and buffers a full formatted line (up to FIFO_DEPTH bytes). It serialises each byte as 8N1: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. Frames go out back-to-back with no idle gap while data remains.

---
 rtl/uart_tx_fifo.sv | 193 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small circular byte FIFO.
// Frames are sent back-to-back while bytes remain; tx is taken straight from a flop.
module uart_tx_fifo #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [7:0]                       s_tdata,
  input  logic                             s_tvalid,
  output logic                             s_tready,
  output logic                             tx,
  output logic                             busy,
  output logic                             tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

  localparam int DIV = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int TW  = $clog2(DIV);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TW-1:0]   r_timer;
  logic [TW-1:0]   w_timer_nxt;
  logic [2:0]      r_bit_idx;
  logic [2:0]      w_bit_idx_nxt;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_nxt;
  logic            w_tx_nxt;
  logic            w_done_nxt;
  logic            w_pop;
  logic            w_push;
  logic            w_nonempty;
  logic            w_timer_last;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_nxt;
  logic            r_ready;
  logic            r_tx;
  logic            r_busy;
  logic            r_tx_done;

  assign w_push       = s_tvalid & r_ready;
  assign w_nonempty   = (r_count != {CW{1'b0}});
  assign w_timer_last = (r_timer == TIMER_LAST);

  assign s_tready   = r_ready;
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign tx_done    = r_tx_done;
  assign fifo_count = r_count;

  // Occupancy after this edge's push and pop.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO storage; entries need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_tdata;
    end
  end

  // FIFO pointers, count and the registered ready flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_ready  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != FULL_COUNT);
    end
  end

  // Serialiser next-state logic; w_tx_nxt is the line level for the current state.
  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer + TW'(1);
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_pop         = 1'b0;
    w_tx_nxt      = 1'b1;
    w_done_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_timer_nxt = {TW{1'b0}};
        if (w_nonempty) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_state_nxt = ST_START;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        w_tx_nxt = 1'b0;
        if (w_timer_last) begin
          w_timer_nxt   = {TW{1'b0}};
          w_bit_idx_nxt = 3'd0;
          w_state_nxt   = ST_DATA;
        end else begin
          w_state_nxt = ST_START;
        end
      end
      ST_DATA: begin
        w_tx_nxt = r_shift[0];
        if (w_timer_last) begin
          w_timer_nxt = {TW{1'b0}};
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_timer_last) begin
          w_done_nxt  = 1'b1;
          w_timer_nxt = {TW{1'b0}};
          // Chaining straight into START keeps frames gap-free.
          if (w_nonempty) begin
            w_pop       = 1'b1;
            w_shift_nxt = r_mem[r_rd_ptr];
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_STOP;
        end
      end
      default: begin
        w_timer_nxt = {TW{1'b0}};
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Serialiser state and registered line outputs (one cycle behind the state).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_timer   <= {TW{1'b0}};
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_tx_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
      r_busy    <= (r_state != ST_IDLE);
      r_tx_done <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-position model checked every cycle, a line decoder,
// and directed scenarios with hand-computed timing.
module tb_uart_tx_fifo;

  localparam int DIV   = 10;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * DIV;
  localparam int HIST  = 16384;

  logic       clk;
  logic       reset;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tready;
  logic       tx;
  logic       busy;
  logic       tx_done;
  logic [2:0] fifo_count;

  logic       d_reset;
  logic [7:0] d_tdata;
  logic       d_tvalid;
  logic       d_tready;
  logic       d_tx;
  logic       d_busy;
  logic       d_done;
  logic [4:0] d_count;

  uart_tx_fifo #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(reset), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .tx(tx), .busy(busy), .tx_done(tx_done), .fifo_count(fifo_count)
  );

  uart_tx_fifo u_dut_def (
    .clk(clk), .reset(d_reset), .s_tdata(d_tdata), .s_tvalid(d_tvalid), .s_tready(d_tready),
    .tx(d_tx), .busy(d_busy), .tx_done(d_done), .fifo_count(d_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // model state
  logic [7:0] mq [$];
  bit         m_on = 0;
  int         m_f  = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_valid = 0;
  bit         rst_edge = 0;
  logic       e_tx, e_busy, e_done, e_ready;
  int         e_count;

  // observation state
  logic       hist [HIST];
  logic       prev_tx = 1'b1;
  bit         rx_on = 0;
  int         rx_s = 0;
  int         starts [$];
  logic [7:0] rx_q [$];
  int         busy_cnt, done_cnt, max_count, ready_low;

  logic [7:0] msg [10] = '{8'h56, 8'h3A, 8'h30, 8'h30, 8'h31, 8'h32, 8'h33, 8'h6D, 8'h0D, 8'h0A};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    else if (k <= 8) return b[k-1];
    else return 1'b1;
  endfunction

  // A line frame occupies FRAME serialiser cycles; tx shows each position one cycle later.
  task automatic model_step();
    bit do_push, at_last;
    rst_edge = 0;
    if (reset) begin
      mq.delete();
      m_on = 0; m_f = 0;
      e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      m_valid = 1; rst_edge = 1;
    end else begin
      do_push = s_tvalid && (mq.size() != DEPTH);
      at_last = m_on && (m_f == FRAME - 1);
      e_tx    = m_on ? frame_bit(m_cur, m_f / DIV) : 1'b1;
      e_done  = at_last;
      e_busy  = m_on;
      if ((!m_on || at_last) && mq.size() != 0) begin
        m_cur = mq.pop_front(); m_on = 1; m_f = 0;
      end else if (at_last) begin
        m_on = 0;
      end else if (m_on) begin
        m_f++;
      end
      if (do_push) mq.push_back(s_tdata);
    end
    e_count = mq.size();
    e_ready = (mq.size() != DEPTH);
  endtask

  task automatic observe();
    logic [7:0] b;
    int idx;
    if (m_valid) begin
      check("tx", tx, e_tx);
      check("busy", busy, e_busy);
      check("tx_done", tx_done, e_done);
      check("fifo_count", fifo_count, e_count);
      check("s_tready", s_tready, e_ready);
    end
    if (!s_tready) begin
      ready_low++;
      check("ready_low_count", fifo_count, DEPTH);
    end
    if (busy) busy_cnt++;
    if (tx_done) done_cnt++;
    if (int'(fifo_count) > max_count) max_count = fifo_count;
    if (cyc < HIST) hist[cyc] = tx;
    if (rst_edge) begin
      rx_on = 0;
    end else if (rx_on && cyc == rx_s + FRAME - 1) begin
      for (int i = 0; i < 8; i++) begin
        idx = rx_s + DIV * (i + 1) + DIV / 2;
        b[i] = (idx < HIST) ? hist[idx] : 1'bx;
      end
      rx_q.push_back(b);
      rx_on = 0;
    end else if (!rx_on && prev_tx === 1'b1 && tx === 1'b0) begin
      rx_on = 1; rx_s = cyc; starts.push_back(cyc);
    end
    prev_tx = tx;
  endtask

  // One clock: model at the rising edge, DUT sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    observe();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_obs();
    starts.delete(); rx_q.delete();
    busy_cnt = 0; done_cnt = 0; max_count = 0; ready_low = 0;
  endtask

  task automatic push_byte(input logic [7:0] b, output int acc);
    bit got;
    got = 0; acc = -1;
    s_tdata = b; s_tvalid = 1'b1;
    for (int n = 0; n < 600 && !got; n++) begin
      got = s_tready;
      tick();
      if (got) acc = cyc;
    end
    s_tvalid = 1'b0;
    check("push_accepted", got, 1);
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int i = 0; i < budget && rx_q.size() < n; i++) tick();
    check("rx_frames", rx_q.size(), n);
  endtask

  function automatic int start_at(input int i);
    return (i < starts.size()) ? starts[i] : -100000;
  endfunction

  function automatic logic [31:0] rx_at(input int i);
    return (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hFFFF_FFFF;
  endfunction

  initial begin
    int acc, acc2, s, w;
    reset = 1'b1; s_tvalid = 1'b0; s_tdata = 8'h00;
    d_reset = 1'b1; d_tvalid = 1'b0; d_tdata = 8'h00;
    idle(3);
    reset = 1'b0;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ready", s_tready, 1);
    check("rst_def_tx", d_tx, 1);
    idle(5);

    // 1: single byte
    clear_obs();
    push_byte(8'h56, acc);
    wait_rx(1, 200);
    check("t1_latency", start_at(0) - acc, 2);
    check("t1_byte", rx_at(0), 8'h56);
    idle(20);
    check("t1_busy_cycles", busy_cnt, 100);
    check("t1_done_pulses", done_cnt, 1);

    // 2: back-to-back line
    clear_obs();
    for (int i = 0; i < 10; i++) push_byte(msg[i], acc);
    wait_rx(10, 1200);
    for (int i = 0; i < 10; i++) check("t2_byte", rx_at(i), msg[i]);
    for (int i = 1; i < 10; i++) check("t2_start_spacing", start_at(i) - start_at(i-1), FRAME);
    check("t2_ready_dropped", ready_low > 0, 1);
    idle(20);
    check("t2_done_pulses", done_cnt, 10);
    check("t2_idle", busy, 0);

    // 3: full boundary with 0xAA held
    clear_obs();
    push_byte(8'h11, acc);
    push_byte(8'h22, acc);
    push_byte(8'h33, acc);
    push_byte(8'h44, acc);
    push_byte(8'h55, acc);
    check("t3_full", fifo_count, 4);
    push_byte(8'hAA, acc2);
    check("t3_accept_after_pop", acc2 - start_at(0), FRAME);
    wait_rx(6, 700);
    check("t3_b0", rx_at(0), 8'h11);
    check("t3_b1", rx_at(1), 8'h22);
    check("t3_b2", rx_at(2), 8'h33);
    check("t3_b3", rx_at(3), 8'h44);
    check("t3_b4", rx_at(4), 8'h55);
    check("t3_b5", rx_at(5), 8'hAA);
    check("t3_max_count", max_count, 4);
    idle(20);

    // 4: push on the STOP->START pop edge with count 2
    clear_obs();
    push_byte(8'h01, acc);
    push_byte(8'h02, acc);
    push_byte(8'h03, acc);
    s = start_at(0);
    while (cyc < s + FRAME - 2 && cyc < s + 1000) tick();
    check("t4_count_before", fifo_count, 2);
    s_tdata = 8'h04; s_tvalid = 1'b1;
    check("t4_ready", s_tready, 1);
    tick();
    s_tvalid = 1'b0;
    check("t4_count_kept", fifo_count, 2);
    check("t4_done_now", tx_done, 1);
    wait_rx(4, 600);
    for (int i = 0; i < 4; i++) check("t4_order", rx_at(i), i + 1);
    idle(20);

    // 5: reset during data bit 3 with three bytes buffered
    clear_obs();
    push_byte(8'h61, acc);
    push_byte(8'h62, acc);
    push_byte(8'h63, acc);
    push_byte(8'h64, acc);
    s = start_at(0);
    while (cyc < s + 42 && cyc < s + 1000) tick();
    check("t5_count_before", fifo_count, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_tx", tx, 1);
    check("t5_busy", busy, 0);
    check("t5_count", fifo_count, 0);
    check("t5_ready", s_tready, 1);
    idle(300);
    check("t5_no_frames", starts.size(), 1);
    check("t5_no_bytes", rx_q.size(), 0);
    clear_obs();
    push_byte(8'h41, acc);
    wait_rx(1, 200);
    check("t5_latency", start_at(0) - acc, 2);
    check("t5_byte", rx_at(0), 8'h41);
    idle(20);

    // 6: default divisor start bit width
    d_reset = 1'b0;
    idle(2);
    check("t6_ready", d_tready, 1);
    d_tdata = 8'h0D; d_tvalid = 1'b1;
    tick();
    acc = cyc;
    d_tvalid = 1'b0;
    for (int i = 0; i < 20 && d_tx; i++) tick();
    check("t6_latency", cyc - acc, 2);
    check("t6_busy", d_busy, 1);
    w = 0;
    for (int i = 0; i < 2000 && !d_tx; i++) begin
      w++;
      tick();
    end
    check("t6_start_width", w, 868);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
